// File: rtl/sha256_nonce_scheduler.sv
// Nonce-search sequencer for one sha256_duct: builds {header, nonce}, runs the duct,
// reads back its zero flag and stops on hit, range end, watchdog expiry or abort.
module sha256_nonce_scheduler #(
    parameter int READ_CYC = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic         inclk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [479:0] header,
    input  logic [31:0]  nonce_first,
    input  logic [31:0]  nonce_last,
    output logic [511:0] block_n,
    output logic         duct_reset_n,
    output logic         readout,
    input  logic         ask,
    input  logic         result,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         timeout,
    output logic [31:0]  found_nonce,
    output logic [31:0]  tries
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_READ  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam logic [3:0]  RD_LAST   = 4'(READ_CYC - 1);

    state_t         state_q, state_d;
    logic [479:0]   header_q, header_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    last_q, last_d;
    logic [15:0]    wd_q, wd_d;
    logic           ask_dly_q, ask_dly_d;
    logic [3:0]     rd_q, rd_d;
    logic           done_q, done_d;
    logic           found_q, found_d;
    logic           timeout_q, timeout_d;
    logic [31:0]    found_nonce_q, found_nonce_d;
    logic [31:0]    tries_q, tries_d;
    logic           duct_rn_q, duct_rn_d;
    logic           readout_q, readout_d;
    logic           busy_q, busy_d;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d       = state_q;
        header_d      = header_q;
        nonce_d       = nonce_q;
        last_d        = last_q;
        wd_d          = wd_q;
        ask_dly_d     = ask;
        rd_d          = rd_q;
        done_d        = 1'b0;
        found_d       = found_q;
        timeout_d     = timeout_q;
        found_nonce_d = found_nonce_q;
        tries_d       = tries_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    header_d      = header;
                    nonce_d       = nonce_first;
                    last_d        = nonce_last;
                    found_d       = 1'b0;
                    timeout_d     = 1'b0;
                    found_nonce_d = 32'd0;
                    tries_d       = 32'd0;
                    state_d       = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                wd_d      = 16'd0;
                ask_dly_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                // A completing digest beats a simultaneous watchdog expiry
                if (ask && !ask_dly_q) begin
                    rd_d    = 4'd0;
                    state_d = ST_READ;
                end else if (wd_q == TIMEOUT_W) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            ST_READ: begin
                if (rd_q == RD_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    rd_d = rd_q + 4'd1;
                end
            end
            ST_CHECK: begin
                tries_d = tries_q + 32'd1;
                if (!result) begin
                    found_nonce_d = nonce_q;
                    found_d       = 1'b1;
                    done_d        = 1'b1;
                    state_d       = ST_IDLE;
                end else if (nonce_q == last_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards whatever the state logic decided this cycle
        if (abort) begin
            state_d       = ST_IDLE;
            header_d      = header_q;
            nonce_d       = nonce_q;
            last_d        = last_q;
            done_d        = 1'b0;
            found_d       = found_q;
            timeout_d     = timeout_q;
            found_nonce_d = found_nonce_q;
            tries_d       = tries_q;
        end else begin
            done_d = done_d;
        end

        busy_d    = (state_d != ST_IDLE);
        duct_rn_d = (state_d == ST_RUN) || (state_d == ST_READ) || (state_d == ST_CHECK);
        readout_d = (state_d == ST_READ) || (state_d == ST_CHECK);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            header_q      <= 480'd0;
            nonce_q       <= 32'd0;
            last_q        <= 32'd0;
            wd_q          <= 16'd0;
            ask_dly_q     <= 1'b0;
            rd_q          <= 4'd0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            timeout_q     <= 1'b0;
            found_nonce_q <= 32'd0;
            tries_q       <= 32'd0;
            duct_rn_q     <= 1'b0;
            readout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            header_q      <= header_d;
            nonce_q       <= nonce_d;
            last_q        <= last_d;
            wd_q          <= wd_d;
            ask_dly_q     <= ask_dly_d;
            rd_q          <= rd_d;
            done_q        <= done_d;
            found_q       <= found_d;
            timeout_q     <= timeout_d;
            found_nonce_q <= found_nonce_d;
            tries_q       <= tries_d;
            duct_rn_q     <= duct_rn_d;
            readout_q     <= readout_d;
            busy_q        <= busy_d;
        end
    end

    assign block_n      = {header_q, nonce_q};
    assign duct_reset_n = duct_rn_q;
    assign readout      = readout_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign timeout      = timeout_q;
    assign found_nonce  = found_nonce_q;
    assign tries        = tries_q;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Directed bench for sha256_nonce_scheduler with a behavioural duct model:
// table-driven search ranges plus hand-written watchdog, abort, reset and start/header cases.
module tb_sha256_nonce_scheduler;

    logic         inclk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [479:0] header = 480'd0;
    logic [31:0]  nonce_first = 32'd0;
    logic [31:0]  nonce_last = 32'd0;
    logic [511:0] block_n;
    logic         duct_reset_n, readout, ask, result;
    logic         busy, done, found, timeout;
    logic [31:0]  found_nonce, tries;

    logic         start_wd = 1'b0;
    logic         abort_wd = 1'b0;
    logic         ask_wd = 1'b0;
    logic         result_wd = 1'b1;
    logic [511:0] block_n_wd;
    logic         duct_reset_n_wd, readout_wd, busy_wd, done_wd, found_wd, timeout_wd;
    logic [31:0]  found_nonce_wd, tries_wd;

    always #5 inclk = ~inclk;

    sha256_nonce_scheduler dut (
        .inclk(inclk), .reset(reset), .start(start), .abort(abort),
        .header(header), .nonce_first(nonce_first), .nonce_last(nonce_last),
        .block_n(block_n), .duct_reset_n(duct_reset_n), .readout(readout),
        .ask(ask), .result(result), .busy(busy), .done(done), .found(found),
        .timeout(timeout), .found_nonce(found_nonce), .tries(tries)
    );

    sha256_nonce_scheduler #(.READ_CYC(2), .TIMEOUT(50)) dut_wd (
        .inclk(inclk), .reset(reset), .start(start_wd), .abort(abort_wd),
        .header(header), .nonce_first(nonce_first), .nonce_last(nonce_last),
        .block_n(block_n_wd), .duct_reset_n(duct_reset_n_wd), .readout(readout_wd),
        .ask(ask_wd), .result(result_wd), .busy(busy_wd), .done(done_wd), .found(found_wd),
        .timeout(timeout_wd), .found_nonce(found_nonce_wd), .tries(tries_wd)
    );

    // Duct model: ask rises 70 cycles after reset_n goes high; result is 0 only on the hit nonce
    logic        hit_en = 1'b0;
    logic [31:0] hit_val = 32'd0;
    int          duct_cnt = 0;
    logic        ask_r = 1'b0;
    always @(posedge inclk) begin
        if (!duct_reset_n) begin
            duct_cnt = 0;
            ask_r <= 1'b0;
        end else begin
            duct_cnt = duct_cnt + 1;
            if (duct_cnt >= 70) ask_r <= 1'b1;
        end
    end
    assign ask    = ask_r;
    assign result = !(hit_en && (block_n[31:0] == hit_val));

    // Record each nonce the duct is released on and the busy low-reset cycles before it
    logic [31:0] seen_q[$];
    int          low_q[$];
    int          low_cnt = 0;
    logic        prev_rn = 1'b0;
    always @(negedge inclk) begin
        if (duct_reset_n && !prev_rn) begin
            seen_q.push_back(block_n[31:0]);
            low_q.push_back(low_cnt);
            low_cnt = 0;
        end else if (!duct_reset_n && busy) begin
            low_cnt = low_cnt + 1;
        end
        prev_rn = duct_reset_n;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] f, input logic [31:0] l, input logic [479:0] h);
        @(negedge inclk);
        seen_q.delete();
        low_q.delete();
        low_cnt = 0;
        header = h;
        nonce_first = f;
        nonce_last = l;
        start = 1'b1;
        @(negedge inclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget && cyc < 0; i++) begin
            @(negedge inclk);
            if (done) cyc = i;
        end
    endtask

    typedef struct {
        logic [31:0] first;
        logic [31:0] last;
        logic        hit_en;
        logic [31:0] hit_val;
        logic        exp_found;
        logic [31:0] exp_fn;
        logic [31:0] exp_tries;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int           cyc;
        logic [479:0] hdr_a, hdr_b;

        vecs[0] = '{32'd5,          32'd20, 1'b1, 32'd9,   1'b1, 32'd9,   32'd5};
        vecs[1] = '{32'd0,          32'd3,  1'b0, 32'd0,   1'b0, 32'd0,   32'd4};
        vecs[2] = '{32'hFFFFFFFE,   32'd1,  1'b1, 32'd0,   1'b1, 32'd0,   32'd3};
        vecs[3] = '{32'd7,          32'd7,  1'b1, 32'd7,   1'b1, 32'd7,   32'd1};
        vecs[4] = '{32'd7,          32'd7,  1'b0, 32'd0,   1'b0, 32'd0,   32'd1};

        repeat (3) @(negedge inclk);
        reset = 1'b0;
        @(negedge inclk);
        chk("rst_block_lo", block_n[31:0], 32'd0);
        chk("rst_block_hi", 32'(block_n[511:32] == 480'd0), 32'd1);
        chk("rst_outs", {26'd0, duct_reset_n, readout, busy, done, found, timeout}, 32'd0);
        chk("rst_found_nonce", found_nonce, 32'd0);
        chk("rst_tries", tries, 32'd0);
        chk("rst_wd_outs", {26'd0, duct_reset_n_wd, readout_wd, busy_wd, done_wd, found_wd, timeout_wd}, 32'd0);

        // Table-driven searches
        for (int v = 0; v < 5; v++) begin
            hdr_a = {15{32'hDEADBEEF ^ 32'(v)}};
            hit_en = vecs[v].hit_en;
            hit_val = vecs[v].hit_val;
            do_start(vecs[v].first, vecs[v].last, hdr_a);
            wait_done(3000, cyc);
            chk($sformatf("v%0d_done_seen", v), 32'(cyc > 0), 32'd1);
            chk($sformatf("v%0d_found", v), {31'd0, found}, {31'd0, vecs[v].exp_found});
            chk($sformatf("v%0d_found_nonce", v), found_nonce, vecs[v].exp_fn);
            chk($sformatf("v%0d_tries", v), tries, vecs[v].exp_tries);
            chk($sformatf("v%0d_timeout", v), {31'd0, timeout}, 32'd0);
            chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_header", v), 32'(block_n[511:32] == hdr_a), 32'd1);
            chk($sformatf("v%0d_seen_cnt", v), 32'(seen_q.size()), vecs[v].exp_tries);
            for (int j = 0; j < seen_q.size(); j++) begin
                chk($sformatf("v%0d_seen%0d", v, j), seen_q[j], vecs[v].first + 32'(j));
                chk($sformatf("v%0d_low%0d", v, j), 32'(low_q[j]), 32'd1);
            end
            @(negedge inclk);
            chk($sformatf("v%0d_done_single", v), {31'd0, done}, 32'd0);
        end

        // Watchdog: duct never answers, TIMEOUT=50
        @(negedge inclk);
        start_wd = 1'b1;
        @(negedge inclk);
        start_wd = 1'b0;
        cyc = -1;
        for (int i = 0; i < 10 && cyc < 0; i++) begin
            @(negedge inclk);
            if (duct_reset_n_wd) cyc = 0;
        end
        chk("wd_run_entered", 32'(cyc == 0), 32'd1);
        cyc = -1;
        for (int i = 1; i <= 200 && cyc < 0; i++) begin
            @(negedge inclk);
            if (done_wd) cyc = i;
        end
        chk("wd_done_cycle", 32'(cyc), 32'd51);
        chk("wd_timeout", {31'd0, timeout_wd}, 32'd1);
        chk("wd_found", {31'd0, found_wd}, 32'd0);
        chk("wd_busy", {31'd0, busy_wd}, 32'd0);

        // Abort in READ of the second nonce
        hit_en = 1'b0;
        do_start(32'd0, 32'd10, {15{32'h12345678}});
        cyc = -1;
        for (int i = 1; i <= 500 && cyc < 0; i++) begin
            @(negedge inclk);
            if (readout && tries == 32'd1) cyc = i;
        end
        chk("abort_reached_read", 32'(cyc > 0), 32'd1);
        abort = 1'b1;
        @(negedge inclk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_found", {31'd0, found}, 32'd0);
        chk("abort_timeout", {31'd0, timeout}, 32'd0);
        chk("abort_duct", {30'd0, duct_reset_n, readout}, 32'd0);
        chk("abort_tries", tries, 32'd1);
        cyc = 0;
        repeat (5) begin
            @(negedge inclk);
            if (done) cyc++;
        end
        chk("abort_no_done", 32'(cyc), 32'd0);

        // Reset pulsed in RUN of the second nonce
        do_start(32'd0, 32'd10, {15{32'h0BADF00D}});
        cyc = -1;
        for (int i = 1; i <= 500 && cyc < 0; i++) begin
            @(negedge inclk);
            if (duct_reset_n && tries == 32'd1) cyc = i;
        end
        chk("rst2_reached_run", 32'(cyc > 0), 32'd1);
        reset = 1'b1;
        @(negedge inclk);
        reset = 1'b0;
        chk("rst2_block_lo", block_n[31:0], 32'd0);
        chk("rst2_block_hi", 32'(block_n[511:32] == 480'd0), 32'd1);
        chk("rst2_outs", {26'd0, duct_reset_n, readout, busy, done, found, timeout}, 32'd0);
        chk("rst2_tries", tries, 32'd0);
        chk("rst2_found_nonce", found_nonce, 32'd0);

        // Start and header change while busy are ignored
        hdr_a = {15{32'hCAFE0001}};
        hdr_b = {15{32'h55AA55AA}};
        hit_en = 1'b1;
        hit_val = 32'd102;
        do_start(32'd100, 32'd102, hdr_a);
        repeat (10) @(negedge inclk);
        header = hdr_b;
        nonce_first = 32'd500;
        nonce_last = 32'd600;
        start = 1'b1;
        @(negedge inclk);
        start = 1'b0;
        wait_done(3000, cyc);
        chk("ign_done_seen", 32'(cyc > 0), 32'd1);
        chk("ign_found_nonce", found_nonce, 32'd102);
        chk("ign_tries", tries, 32'd3);
        chk("ign_header", 32'(block_n[511:32] == hdr_a), 32'd1);
        chk("ign_first_seen", seen_q[0], 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_nonce_scheduler.md
# sha256_nonce_scheduler

Sequencer that drives a `sha256_duct` through a range of nonces for one 480-bit header template. It assembles each 512-bit `block_n` from the header plus the current nonce, releases the duct, waits for its `ask`, then strobes `readout` and samples `result`. It stops on the first nonce whose `result` is 0, on range exhaustion, on watchdog timeout, or on abort. It sits between the host/control logic and a single `sha256_duct` instance.

## Interface

**Parameters**

- `READ_CYC`, default 2: cycles `readout` is held high before `result` is sampled (range 1–15).
- `TIMEOUT`, default 255: maximum cycles spent in RUN waiting for an `ask` rising edge (range 1–65535).

**Ports**

- `inclk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; forces IDLE and all outputs to reset values.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `abort` in 1: return to IDLE next cycle from any state; sets no status flags.
- `header` in 480: template for `block_n[511:32]`; captured on accepted `start`.
- `nonce_first` in 32: first nonce; captured on accepted `start`.
- `nonce_last` in 32: last nonce, inclusive; captured on accepted `start`.
- `block_n` out 512: `{header_q, nonce}` to the duct.
- `duct_reset_n` out 1: to duct `reset_n`; 0 holds the duct cleared.
- `readout` out 1: to duct `readout`.
- `ask` in 1: from duct; a rising edge means the digest of the current block is complete.
- `result` in 1: from duct; 0 means the zero condition is met.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a search ends with FOUND, EXHAUSTED or TIMEOUT.
- `found` out 1: sticky; high if the last search ended with a hit.
- `timeout` out 1: sticky; high if the last search ended by watchdog.
- `found_nonce` out 32: nonce of the hit; valid while `found` is high.
- `tries` out 32: number of nonces fully checked in the current or last search; wraps modulo 2^32.

## Operation

**States:** IDLE, LOAD, RUN, READ, CHECK.

- **IDLE**
  - `duct_reset_n`=0, `readout`=0.
  - On `start`: capture `header`, `nonce_first`, `nonce_last`; set `nonce <= nonce_first`; clear `found`, `timeout`, `tries`, `found_nonce`; go to LOAD.
- **LOAD** (1 cycle)
  - `duct_reset_n`=0 while `block_n` already carries the new nonce.
  - Clear the watchdog counter and the `ask` edge register; go to RUN.
- **RUN**
  - `duct_reset_n`=1; the watchdog increments each cycle.
  - Edge detect: `ask & ~ask_d`, where `ask_d` is the registered `ask`.
  - On an edge: go to READ.
  - Otherwise, when the watchdog reaches `TIMEOUT`: set `timeout`, pulse `done`, go to IDLE.
  - If an edge and the timeout coincide, the edge wins.
- **READ**
  - `readout`=1 for exactly `READ_CYC` cycles; `duct_reset_n` stays 1; then go to CHECK.
- **CHECK** (1 cycle)
  - `readout` stays 1; sample `result`; `tries` increments by 1.
  - If `result`=0: `found_nonce <= nonce`, `found <= 1`, pulse `done`, go to IDLE.
  - Else if `nonce == nonce_last`: pulse `done`, go to IDLE (EXHAUSTED).
  - Else: `nonce <= nonce + 1` (32-bit, wraps 0xFFFFFFFF→0), go to LOAD.

**Range and flag rules**

- If `nonce_first > nonce_last`, the range wraps through zero, which is intended. `nonce_first == nonce_last` checks exactly one nonce.
- `abort` has priority over every transition, including a CHECK hit. It returns to IDLE with `found`, `timeout` and `done` unchanged/0.
- A `start` that arrives while busy is ignored.
- `block_n` holds its last value in IDLE; `duct_reset_n`=0 keeps the duct inert.

## Timing

**Reset values**

- State IDLE.
- `block_n`=0, `duct_reset_n`=0, `readout`=0.
- `busy`=0, `done`=0, `found`=0, `timeout`=0, `found_nonce`=0, `tries`=0, nonce=0.

**Cycle counts**

- `start` sampled at edge k → LOAD during cycle k+1 → RUN from k+2.
- Per-nonce cost = 1 (LOAD) + RUN wait + `READ_CYC` + 1 (CHECK).
- `done` asserts in the cycle after CHECK (or after the timeout cycle), together with `busy`=0.
- `found` / `found_nonce` / `tries` are updated in that same cycle.

**Output registration and reset behaviour**

- All outputs are registered; no combinational path from `ask` or `result` to any output.
- `reset` asserted mid-search: the next cycle shows reset values; no `done` pulse.

## Test plan

The bench duct model raises `ask` 70 cycles after `reset_n` goes high and returns `result`=0 only when `block_n[31:0]` equals a programmed value.

1. **Hit inside range.** `nonce_first`=5, `nonce_last`=20, hit nonce=9 → `done` pulses once, `found`=1, `found_nonce`=9, `tries`=5, `timeout`=0.
2. **Exhaustion.** `nonce_first`=0, `nonce_last`=3, no hit → `done`, `found`=0, `tries`=4. The duct sees `block_n[31:0]` = 0, 1, 2, 3 in order, each preceded by one `duct_reset_n`=0 cycle.
3. **Wrap-around range.** `nonce_first`=0xFFFFFFFE, `nonce_last`=0x1, hit nonce=0x0 → `found_nonce`=0, `tries`=3.
4. **Watchdog.** `TIMEOUT`=50, model never raises `ask` → `timeout`=1 and `done` exactly 51 cycles after RUN entry; `found`=0; `busy`=0.
5. **Abort and reset.**
   - `abort` in READ of the second nonce → IDLE next cycle, `done`=0, `found`=0.
   - A repeat run with `reset` pulsed in RUN → all outputs at reset values the next cycle.
6. **Ignored start and `header` capture.** A `start` issued while busy, plus a `header` change mid-search → both ignored; `block_n[511:32]` equals the header value captured at the original `start`.
